// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and types for the 4-digit scan driver
package seven_seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] BCD_MINUS  = 4'hA;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [3:0] anode_sel(input digit_idx_t idx);
        return AN_ALL_OFF ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_refresh_counter.sv
// rtl/scan_refresh_counter.sv - per-slot divider, slot index and frame-start pulse
module scan_refresh_counter
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    output digit_idx_t o_slot,
    output logic       o_in_gap,
    output logic       o_frame_start
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_div_cnt;
    digit_idx_t       r_slot;
    logic             r_frame_start;
    logic             w_wrap;

    assign w_wrap = (r_div_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
        end else if (!i_enable) begin
            r_div_cnt     <= '0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_wrap) begin
                r_slot <= r_slot + 1'b1;
            end
            // High while the counter sits on slot 0 right after slot 3.
            r_frame_start <= w_wrap && (r_slot == 2'd3);
        end
    end

    assign o_slot        = r_slot;
    assign o_in_gap      = (r_div_cnt < GAP_END);
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/seven_seg_scan_mux.sv
// rtl/seven_seg_scan_mux.sv - 4-digit common-anode scan driver with shadow registers
// and leading-zero suppression; all outputs registered one cycle behind the scan state.
module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_SUPPRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  bcd_out,
    output logic        dp_on_out,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    logic [15:0] r_digits;
    logic [3:0]  r_dp;
    logic [3:0]  r_blank;

    logic [3:0]  r_an;
    logic [3:0]  r_bcd;
    logic        r_dp_on;
    digit_idx_t  r_idx;
    logic        r_tick;

    digit_idx_t  w_slot;
    logic        w_in_gap;
    logic        w_frame_start;
    logic [3:0]  w_digit;
    logic [NUM_DIGITS-1:1] w_zero_run;
    logic        w_suppress;
    logic        w_lit;

    scan_refresh_counter #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .o_slot        (w_slot),
        .o_in_gap      (w_in_gap),
        .o_frame_start (w_frame_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= {NUM_DIGITS{BCD_BLANK}};
            r_dp     <= '0;
            r_blank  <= '1;
        end else if (load) begin
            r_digits <= digits_in;
            r_dp     <= dp_in;
            r_blank  <= blank_in;
        end
    end

    // w_zero_run[k]: digit k and every digit to its left are zero.
    assign w_zero_run[3] = (r_digits[15:12] == 4'h0);
    assign w_zero_run[2] = w_zero_run[3] && (r_digits[11:8] == 4'h0);
    assign w_zero_run[1] = w_zero_run[2] && (r_digits[7:4]  == 4'h0);

    assign w_digit    = r_digits[{w_slot, 2'b00} +: 4];
    assign w_suppress = LZ_SUPPRESS && (w_slot != 2'd0) && w_zero_run[w_slot];
    assign w_lit      = !r_blank[w_slot] && !w_suppress;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= AN_ALL_OFF;
            r_bcd   <= BCD_BLANK;
            r_dp_on <= 1'b0;
            r_idx   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_idx  <= enable ? w_slot : '0;
            r_tick <= enable && w_frame_start;
            if (enable && !w_in_gap && w_lit) begin
                r_an    <= anode_sel(w_slot);
                r_bcd   <= w_digit;
                r_dp_on <= r_dp[w_slot];
            end else begin
                r_an    <= AN_ALL_OFF;
                r_bcd   <= BCD_BLANK;
                r_dp_on <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign bcd_out    = r_bcd;
    assign dp_on_out  = r_dp_on;
    assign digit_idx  = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
Time-multiplexed 4-digit scan driver for the Basys 3 common-anode display. It sits directly upstream of the per-digit BCD-to-7-segment decoder. It latches four BCD digits plus decimal-point and blank flags into shadow registers, then cycles one digit at a time onto the shared decoder input. It drives the matching active-low anode and inserts a short all-off gap between digits to prevent ghosting.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
LZ_SUPPRESS, 1, 1 = blank leading zero digits (digit 3 down to digit 1); digit 0 is never suppressed

Ports:
clk  in  1  system clock
rst_n  in  1  reset: asynchronous, active-low
enable  in  1  1 = scanning; 0 = display dark, scan state held at 0
load  in  1  1-cycle strobe: capture digits_in, dp_in and blank_in into the shadow registers
digits_in  in  16  {d3,d2,d1,d0} BCD, 4'hA = minus, 4'hF = blank; d3 is leftmost
dp_in  in  4  per-digit decimal point request, bit i -> digit i
blank_in  in  4  per-digit force-blank, bit i -> digit i
bcd_out  out  4  digit value to the decoder; 4'hF when nothing is lit
dp_on_out  out  1  decimal point request to the decoder
an  out  4  anodes, active-low, bit i -> digit i
digit_idx  out  2  index of the slot currently scanned
frame_tick  out  1  1-cycle pulse when digit_idx wraps from 3 to 0

Behaviour:
- Reset (async assert, sync release via clk):
  - div_cnt = 0, slot = 0.
  - Shadow digits = 4'hF, shadow dp = 0, shadow blank = 4'b1111.
  - Outputs: an = 4'b1111, bcd_out = 4'hF, dp_on_out = 0, digit_idx = 0, frame_tick = 0.
  - Reset mid-scan behaves identically, with no partial frame.
- Shadow load:
  - load = 1 at a rising edge captures all three inputs in that edge.
  - Load is accepted regardless of enable.
  - New values are used from the next cycle, including mid-slot.
- Scan counter (enable = 1):
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap, slot increments mod 4 (3 -> 0).
  - frame_tick pulses in the cycle the registered outputs first show slot 0 after slot 3.
- Digit lit condition: shadow blank[slot] = 0, and the digit is not a suppressed leading zero.
  - Leading-zero rule (LZ_SUPPRESS = 1): digit k in 3..1 is suppressed if it and every digit above it equal 4'h0.
  - 4'hA and 4'hF count as non-zero for this rule.
- Output mapping: all outputs are registered and show the state of the previous cycle (1-cycle latency).
  - If div_cnt < BLANK_CYCLES, or the digit is not lit: an = 4'b1111, bcd_out = 4'hF, dp_on_out = 0.
  - Otherwise: an = ~(4'b0001 << slot), bcd_out = shadow digit[slot], dp_on_out = shadow dp[slot].
  - digit_idx always equals slot, even when the digit is dark.
- Exactly zero or one anode is low in any cycle.
- enable = 0:
  - div_cnt and slot are forced to 0.
  - Outputs take the dark values; frame_tick = 0.
  - When enable returns to 1, the scan restarts at slot 0 with div_cnt = 0.
- No overflow condition exists; div_cnt is ceil(log2(REFRESH_DIV)) bits wide.

Decomposition:
- Package seven_seg_pkg holds the constants NUM_DIGITS = 4, BCD_BLANK = 4'hF, BCD_MINUS = 4'hA, AN_ALL_OFF = 4'b1111, and the 2-bit digit-index type.
- One sub-module, scan_refresh_counter, owns div_cnt, slot and the wrap/frame pulse, and outputs slot and in_gap.
- Shadow registers, leading-zero logic and the output registers stay in the top module.

Test Plan (bench runs with REFRESH_DIV = 8, BLANK_CYCLES = 2):
1. Reset release, enable = 1, load digits 16'h1234, dp 4'b0100, blank 0 -> per slot: 2 cycles of an = 1111 and bcd_out = F, then 6 cycles of an = 1110 with bcd_out = 4; next slots give an = 1101/3, 1011/2 with dp_on_out = 1, then 0111/1. frame_tick fires once every 32 cycles.
2. LZ_SUPPRESS = 1, digits 16'h0005 -> an stays 1111 in slots 3..1, and an = 1110 with bcd_out = 5 in slot 0. Digits 16'h0000 -> only digit 0 is lit, showing 0. Digits 16'hA005 -> digits 3 (minus), 2, 1 (zeros) and 0 are all lit.
3. blank_in = 4'b1010 with digits 16'h1234 -> digits 3 and 1 are never lit; digit_idx still steps 0,1,2,3.
4. Assert load mid-slot 2 with new digits 16'h9999 -> bcd_out changes to 9 one cycle after the load edge; an is unchanged across the update.
5. enable = 0 during slot 2 -> the next cycle shows an = 1111 and digit_idx = 0. Re-enable -> 2 gap cycles, then an = 1110.
6. rst_n = 0 asserted asynchronously mid-slot -> an = 1111 and bcd_out = F immediately, with no clk edge needed; shadow is blank after release until a load.
